sphere_batch_sched: RTL and testbench
=====================================

Name: sphere_batch_sched

Overview:
- Two-requester batch scheduler in front of one sphere_fsm_32bit_simple point generator.
- Accepts batch commands: start index, point count and base selects.
- Arbitrates round-robin between requesters and sequences the core one point at a time (ready/start/done).
- Streams each Q16.16 (x,y,z) result out with valid/ready backpressure, tagged with requester id and index.

Parameters:
CNT_W, 16, width of batch point count
TIMEOUT, 1024, max cycles from core_start to core_done before error

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cmd_valid  in  2  per-requester command valid
cmd_ready  out  2  per-requester command accept
cmd_k  in  2x32  per-requester start index (packed, req i at [32i+:32])
cmd_count  in  2xCNT_W  per-requester point count
cmd_base0  in  2x2  per-requester base_sel0
cmd_base1  in  2x2  per-requester base_sel1
core_start  out  1  start pulse to core
core_k  out  32  index to core
core_base0  out  2  base_sel0 to core
core_base1  out  2  base_sel1 to core
core_ready  in  1  core idle
core_done  in  1  core result valid
core_x, core_y, core_z  in  32 each  core results
out_valid  out  1  result valid
out_ready  in  1  downstream accept
out_x, out_y, out_z  out  32 each  held results
out_k  out  32  index of this point
out_id  out  1  owning requester
out_last  out  1  final point of batch
batch_done  out  2  one-cycle pulse per requester on batch completion
err_timeout  out  1  sticky watchdog error

Behaviour:
- Reset: clk and rst as stated; reset is synchronous and active-high. State=IDLE. All outputs 0; rr pointer=0; err_timeout=0. Reset mid-batch drops the batch and any pending core result; core_start stays 0 in the reset cycle.
- FSM states: IDLE, ISSUE, WAIT, OUT.
- IDLE:
  - cmd_ready is combinational and one-hot to the arbitration winner; 0 if no cmd_valid.
  - Winner is the requester at rr pointer if valid, else the other.
  - On handshake, latch k, count, bases and id. Set rr pointer to the other requester.
  - count==0: pulse batch_done[id] next cycle; stay IDLE; no core activity.
  - count>0: go to ISSUE.
- ISSUE: wait for core_ready=1. Then drive core_start=1 for exactly one cycle with core_k/core_base0/core_base1 = latched values (held stable through WAIT). Clear watchdog counter; go to WAIT.
- WAIT:
  - On first cycle with core_done=1, register core_x/y/z into out_x/y/z. Set out_k=k, out_id=id, out_last=(remaining==1), out_valid=1; go to OUT.
  - Watchdog: if core_done is not seen within TIMEOUT cycles, set err_timeout=1 (sticky until rst), abort the batch, pulse batch_done[id], go to IDLE.
- OUT:
  - out_* held stable while out_valid && !out_ready.
  - On out_valid && out_ready: out_valid=0, k=k+1 (32-bit wrap, 0xFFFFFFFF→0), remaining−1.
  - If remaining was 1: batch_done[id] pulses the same cycle; go to IDLE. Else go to ISSUE.
- Latency: with core_ready high and out_ready high, core_start fires 1 cycle after ISSUE entry. out_valid rises 1 cycle after core_done. The next core_start fires 2 cycles after the out handshake.
- No new command is accepted until the current batch completes; batches are not interleaved.
- Simultaneous cmd_valid from both requesters: rr pointer decides. Back-to-back batches alternate requesters.

Decomposition:
- Package sphere_sched_pkg: FSM state enum; base-select encodings (0→2, 1→3, 2→7); Q16.16 FRAC_BITS=16.
- One sub-module: sphere_rr_arb2, a two-way round-robin arbiter (grant, pointer update on accept).

Test Plan:
- Single batch, req0 k=1 count=3 bases(0,1), real core, out_ready=1 → three outputs with out_k=1,2,3 and out_last only on k=3. k=1 gives x=0xFFFF8000, y=0x0000DDB3, z=0 (each ±1 LSB); batch_done[0] one pulse.
- Both requesters valid in the same cycle after reset: req0 k=1 count=2, req1 k=10 count=1 → req0 served first (rr=0), then req1. out_id sequence 0,0,1.
- Backpressure: out_ready=0 for 20 cycles mid-batch → out_* stable, no core_start issued; resumes on out_ready=1 with no lost or duplicated point.
- count=0 command → cmd_ready handshake, batch_done pulse, core_start never asserted.
- k=0xFFFFFFFF count=2 → out_k=0xFFFFFFFF then 0x00000000.
- Core stub that never asserts core_done, TIMEOUT=16 → err_timeout rises 16 cycles after core_start and batch_done pulses. rst asserted mid-WAIT → all outputs 0 and FSM in IDLE on the next cycle.

Source files
------------

// File: rtl/sphere_sched_pkg.sv
// Shared types and constants for the sphere batch scheduler.
package sphere_sched_pkg;

    localparam int unsigned FRAC_BITS = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        OUT   = 2'd3
    } state_t;

    // Radical-inverse base selected by a 2-bit base select.
    function automatic logic [2:0] base_value(input logic [1:0] sel);
        case (sel)
            2'd0:    return 3'd2;
            2'd1:    return 3'd3;
            default: return 3'd7;
        endcase
    endfunction

endpackage

// File: rtl/sphere_rr_arb2.sv
// Two-way round-robin arbiter; pointer moves past the winner on accept.
module sphere_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant_c,
    output logic       win_c
);

    logic ptr;

    always_comb begin
        win_c   = req[ptr] ? ptr : ~ptr;
        grant_c = (|req) ? {win_c, ~win_c} : 2'b00;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= 1'b0;
        end else if (accept) begin
            ptr <= ~win_c;
        end
    end

endmodule

// File: rtl/sphere_batch_sched.sv
// Batch scheduler: arbitrates two requesters and sequences one point
// generator core one point at a time, streaming results downstream.
module sphere_batch_sched
    import sphere_sched_pkg::*;
#(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         cmd_valid,
    output logic [1:0]         cmd_ready,
    input  logic [63:0]        cmd_k,
    input  logic [2*CNT_W-1:0] cmd_count,
    input  logic [3:0]         cmd_base0,
    input  logic [3:0]         cmd_base1,
    output logic               core_start,
    output logic [31:0]        core_k,
    output logic [1:0]         core_base0,
    output logic [1:0]         core_base1,
    input  logic               core_ready,
    input  logic               core_done,
    input  logic [31:0]        core_x,
    input  logic [31:0]        core_y,
    input  logic [31:0]        core_z,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_x,
    output logic [31:0]        out_y,
    output logic [31:0]        out_z,
    output logic [31:0]        out_k,
    output logic               out_id,
    output logic               out_last,
    output logic [1:0]         batch_done,
    output logic               err_timeout
);

    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

    state_t            state;
    logic [31:0]       k;
    logic [CNT_W-1:0]  remaining;
    logic [1:0]        base0;
    logic [1:0]        base1;
    logic              id;
    logic [WD_W-1:0]   wd_cnt;

    logic [1:0]        grant_c;
    logic              win_c;
    logic              accept;
    logic [31:0]       sel_k;
    logic [CNT_W-1:0]  sel_count;
    logic [1:0]        sel_base0;
    logic [1:0]        sel_base1;

    // Commands are only taken while idle and never during reset.
    assign accept    = (state == IDLE) && (|cmd_valid) && !rst;
    assign cmd_ready = accept ? grant_c : 2'b00;

    sphere_rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (cmd_valid),
        .accept  (accept),
        .grant_c (grant_c),
        .win_c   (win_c)
    );

    always_comb begin
        sel_k     = win_c ? cmd_k[63:32]              : cmd_k[31:0];
        sel_count = win_c ? cmd_count[2*CNT_W-1:CNT_W] : cmd_count[CNT_W-1:0];
        sel_base0 = win_c ? cmd_base0[3:2]            : cmd_base0[1:0];
        sel_base1 = win_c ? cmd_base1[3:2]            : cmd_base1[1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            k           <= '0;
            remaining   <= '0;
            base0       <= '0;
            base1       <= '0;
            id          <= 1'b0;
            wd_cnt      <= '0;
            core_start  <= 1'b0;
            core_k      <= '0;
            core_base0  <= '0;
            core_base1  <= '0;
            out_valid   <= 1'b0;
            out_x       <= '0;
            out_y       <= '0;
            out_z       <= '0;
            out_k       <= '0;
            out_id      <= 1'b0;
            out_last    <= 1'b0;
            batch_done  <= 2'b00;
            err_timeout <= 1'b0;
        end else begin
            core_start <= 1'b0;
            batch_done <= 2'b00;
            case (state)
                IDLE: begin
                    if (accept) begin
                        k         <= sel_k;
                        remaining <= sel_count;
                        base0     <= sel_base0;
                        base1     <= sel_base1;
                        id        <= win_c;
                        if (sel_count == '0) begin
                            batch_done <= {win_c, ~win_c};
                        end else begin
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (core_ready) begin
                        core_start <= 1'b1;
                        core_k     <= k;
                        core_base0 <= base0;
                        core_base1 <= base1;
                        wd_cnt     <= '0;
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    // Watchdog gives the core TIMEOUT cycles, counting the start cycle.
                    if (core_done) begin
                        out_x     <= core_x;
                        out_y     <= core_y;
                        out_z     <= core_z;
                        out_k     <= k;
                        out_id    <= id;
                        out_last  <= (remaining == CNT_W'(1));
                        out_valid <= 1'b1;
                        state     <= OUT;
                    end else if (wd_cnt == WD_W'(TIMEOUT - 1)) begin
                        err_timeout <= 1'b1;
                        batch_done  <= {id, ~id};
                        state       <= IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + WD_W'(1);
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        k         <= k + 32'd1;
                        remaining <= remaining - CNT_W'(1);
                        if (remaining == CNT_W'(1)) begin
                            batch_done <= {id, ~id};
                            state      <= IDLE;
                        end else begin
                            state <= ISSUE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sphere_batch_sched.sv
// Randomised bench for sphere_batch_sched with a stub core and an event-level model.
module tb_sphere_batch_sched;
    import sphere_sched_pkg::*;

    localparam int TO = 16;

    typedef struct packed {
        logic [31:0] k;
        logic [15:0] cnt;
        logic [1:0]  b0;
        logic [1:0]  b1;
    } cmd_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  cmd_valid = 2'b00;
    logic [1:0]  cmd_ready;
    logic [63:0] cmd_k = '0;
    logic [31:0] cmd_count = '0;
    logic [3:0]  cmd_base0 = '0;
    logic [3:0]  cmd_base1 = '0;
    logic        core_start;
    logic [31:0] core_k;
    logic [1:0]  core_base0, core_base1;
    logic        core_ready = 1'b1;
    logic        core_done = 1'b0;
    logic [31:0] core_x = '0, core_y = '0, core_z = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_x, out_y, out_z, out_k;
    logic        out_id, out_last;
    logic [1:0]  batch_done;
    logic        err_timeout;

    sphere_batch_sched #(.CNT_W(16), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_k(cmd_k), .cmd_count(cmd_count), .cmd_base0(cmd_base0), .cmd_base1(cmd_base1),
        .core_start(core_start), .core_k(core_k), .core_base0(core_base0), .core_base1(core_base1),
        .core_ready(core_ready), .core_done(core_done),
        .core_x(core_x), .core_y(core_y), .core_z(core_z),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_x(out_x), .out_y(out_y), .out_z(out_z), .out_k(out_k),
        .out_id(out_id), .out_last(out_last), .batch_done(batch_done), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    // Stub result: any deterministic function of index and bases will do.
    function automatic logic [95:0] core_fn(input logic [31:0] k, input logic [1:0] b0,
                                            input logic [1:0] b1);
        logic [31:0] x, y, z;
        x = k ^ (32'(base_value(b0)) << FRAC_BITS);
        y = (k * 32'd3) + {b1, 30'h0};
        z = {k[15:0], k[31:16]} ^ 32'(base_value(b1));
        return {x, y, z};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- requester drivers ----------------
    cmd_t rq0[$];
    cmd_t rq1[$];
    logic [1:0] hs = 2'b00;

    task automatic push_cmd(input int r, input logic [31:0] k, input int cnt, input int b0, input int b1);
        cmd_t c;
        c.k = k; c.cnt = 16'(cnt); c.b0 = 2'(b0); c.b1 = 2'(b1);
        if (r == 0) rq0.push_back(c); else rq1.push_back(c);
    endtask

    always @(negedge clk) begin
        cmd_t c;
        if (hs[0] && rq0.size() > 0) void'(rq0.pop_front());
        if (hs[1] && rq1.size() > 0) void'(rq1.pop_front());
        cmd_valid = {1'(rq1.size() > 0), 1'(rq0.size() > 0)};
        if (rq0.size() > 0) begin
            c = rq0[0];
            cmd_k[31:0] = c.k; cmd_count[15:0] = c.cnt; cmd_base0[1:0] = c.b0; cmd_base1[1:0] = c.b1;
        end
        if (rq1.size() > 0) begin
            c = rq1[0];
            cmd_k[63:32] = c.k; cmd_count[31:16] = c.cnt; cmd_base0[3:2] = c.b0; cmd_base1[3:2] = c.b1;
        end
    end

    // ---------------- downstream ready ----------------
    int ord_mode = 0;  // 0: always ready, 1: random, 2: stalled
    always @(negedge clk) begin
        out_ready = (ord_mode == 0) ? 1'b1 :
                    (ord_mode == 2) ? 1'b0 : 1'($urandom_range(0, 2) != 0);
    end

    // ---------------- core stub ----------------
    bit          hang = 1'b0;
    bit          stall_core = 1'b0;
    bit          stub_busy = 1'b0;
    int          stub_lat = 0;
    logic [31:0] stub_k = '0;
    logic [1:0]  stub_b0 = '0, stub_b1 = '0;

    always @(negedge clk) begin
        if (core_done) begin
            core_done  = 1'b0;
            core_ready = 1'b1;
        end
        if (stub_busy) begin
            stub_lat--;
            if (stub_lat == 0) begin
                {core_x, core_y, core_z} = core_fn(stub_k, stub_b0, stub_b1);
                core_done = 1'b1;
                stub_busy = 1'b0;
            end
        end else if (core_start && !hang) begin
            stub_k = core_k; stub_b0 = core_base0; stub_b1 = core_base1;
            stub_lat = int'($urandom_range(1, 6));
            stub_busy = 1'b1;
            core_ready = 1'b0;
        end else if (!core_done) begin
            core_ready = stall_core ? 1'($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    // ---------------- behavioural model + compare ----------------
    bit          m_valid = 1'b0;
    logic        m_rr = 1'b0;
    bit          m_busy = 1'b0;
    bit          m_iss = 1'b0;
    bit          m_inflight = 1'b0;
    int          m_start_at = 0;
    logic        m_id = 1'b0;
    logic [1:0]  m_b0 = '0, m_b1 = '0;
    logic [31:0] pts[$];
    logic        m_win;
    logic [1:0]  exp_ready;
    logic [31:0] acc_k;
    logic [15:0] acc_cnt;

    bit          e_start = 1'b0, e_ov = 1'b0, e_err = 1'b0, chk_zero = 1'b0;
    logic [1:0]  e_bd = '0;
    logic [31:0] e_ck = '0, e_ox = '0, e_oy = '0, e_oz = '0, e_ok = '0;
    logic [1:0]  e_cb0 = '0, e_cb1 = '0;
    logic        e_oid = 1'b0, e_olast = 1'b0;
    bit          n_start;
    logic [1:0]  n_bd;

    // Observation log for the directed literal checks.
    logic [31:0] log_k[$];
    logic        log_id[$];
    logic        log_last[$];
    int          start_cnt = 0;
    int          last_start_cyc = 0;
    int          err_rise_cyc = 0;
    logic        err_prev = 1'b0;
    int          bd_cnt0 = 0, bd_cnt1 = 0;

    always @(negedge clk) begin
        #1;
        cyc++;
        m_win = cmd_valid[m_rr] ? m_rr : ~m_rr;
        exp_ready = (!rst && !m_busy && (|cmd_valid)) ? {m_win, ~m_win} : 2'b00;
        if (m_valid) begin
            chk("cmd_ready", 32'(cmd_ready), 32'(exp_ready));
            chk("core_start", 32'(core_start), 32'(e_start));
            if (e_start || m_inflight) begin
                chk("core_k", core_k, e_ck);
                chk("core_base0", 32'(core_base0), 32'(e_cb0));
                chk("core_base1", 32'(core_base1), 32'(e_cb1));
            end
            chk("out_valid", 32'(out_valid), 32'(e_ov));
            if (e_ov) begin
                chk("out_x", out_x, e_ox);
                chk("out_y", out_y, e_oy);
                chk("out_z", out_z, e_oz);
                chk("out_k", out_k, e_ok);
                chk("out_id", 32'(out_id), 32'(e_oid));
                chk("out_last", 32'(out_last), 32'(e_olast));
            end
            chk("batch_done", 32'(batch_done), 32'(e_bd));
            chk("err_timeout", 32'(err_timeout), 32'(e_err));
            if (chk_zero) begin
                chk("rst_out_x", out_x, 32'h0);
                chk("rst_out_k", out_k, 32'h0);
                chk("rst_out_flags", 32'({out_id, out_last}), 32'h0);
                chk("rst_core_k", core_k, 32'h0);
            end
        end

        hs = cmd_valid & cmd_ready;
        if (out_valid && out_ready) begin
            log_k.push_back(out_k); log_id.push_back(out_id); log_last.push_back(out_last);
        end
        if (core_start) begin start_cnt++; last_start_cyc = cyc; end
        if (err_timeout && !err_prev) err_rise_cyc = cyc;
        err_prev = err_timeout;
        if (batch_done[0]) bd_cnt0++;
        if (batch_done[1]) bd_cnt1++;

        n_start = 1'b0;
        n_bd = 2'b00;
        if (rst) begin
            m_valid = 1'b1; m_rr = 1'b0; m_busy = 1'b0; m_iss = 1'b0; m_inflight = 1'b0;
            pts.delete();
            e_ov = 1'b0; e_err = 1'b0; chk_zero = 1'b1;
            e_ck = '0; e_cb0 = '0; e_cb1 = '0;
        end else begin
            chk_zero = 1'b0;
            if (m_iss && core_ready) begin
                n_start = 1'b1; m_iss = 1'b0; m_inflight = 1'b1; m_start_at = cyc + 1;
                e_ck = pts[0]; e_cb0 = m_b0; e_cb1 = m_b1;
            end else if (m_inflight && cyc >= m_start_at) begin
                if (core_done) begin
                    {e_ox, e_oy, e_oz} = core_fn(pts[0], m_b0, m_b1);
                    e_ok = pts[0]; e_oid = m_id; e_olast = (pts.size() == 1);
                    e_ov = 1'b1; m_inflight = 1'b0;
                end else if (cyc - m_start_at == TO - 1) begin
                    e_err = 1'b1; n_bd = {m_id, ~m_id};
                    pts.delete(); m_inflight = 1'b0; m_busy = 1'b0;
                end
            end else if (e_ov && out_ready) begin
                e_ov = 1'b0;
                void'(pts.pop_front());
                if (pts.size() == 0) begin
                    n_bd = {m_id, ~m_id}; m_busy = 1'b0;
                end else begin
                    m_iss = 1'b1;
                end
            end
            if (exp_ready != 2'b00) begin
                acc_k   = m_win ? cmd_k[63:32] : cmd_k[31:0];
                acc_cnt = m_win ? cmd_count[31:16] : cmd_count[15:0];
                m_rr = ~m_win;
                if (acc_cnt == 16'd0) begin
                    n_bd = {m_win, ~m_win};
                end else begin
                    m_busy = 1'b1; m_iss = 1'b1; m_id = m_win;
                    m_b0 = m_win ? cmd_base0[3:2] : cmd_base0[1:0];
                    m_b1 = m_win ? cmd_base1[3:2] : cmd_base1[1:0];
                    for (int i = 0; i < int'(acc_cnt); i++) pts.push_back(acc_k + 32'(i));
                end
            end
        end
        e_start = n_start;
        e_bd = n_bd;
    end

    // ---------------- directed + random sequence ----------------
    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (!(rq0.size() == 0 && rq1.size() == 0 && !m_busy && !e_ov) && n < budget) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (n >= budget) begin
            n_bad++;
            $display("FAIL idle_wait: still busy after %0d cycles, required idle", budget);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic clear_log();
        log_k.delete(); log_id.delete(); log_last.delete();
    endtask

    initial begin
        int s0, b0s, b1s, n;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Both requesters at once right after reset: req0 wins first.
        clear_log();
        push_cmd(0, 32'd1, 2, 0, 1);
        push_cmd(1, 32'd10, 1, 2, 0);
        wait_idle(300);
        chk("t2_count", 32'(log_k.size()), 32'd3);
        if (log_k.size() == 3) begin
            chk("t2_id0", 32'(log_id[0]), 32'd0);
            chk("t2_id1", 32'(log_id[1]), 32'd0);
            chk("t2_id2", 32'(log_id[2]), 32'd1);
            chk("t2_k2", log_k[2], 32'd10);
            chk("t2_last", 32'({log_last[0], log_last[1], log_last[2]}), 32'b011);
        end

        // Single batch req0 k=1 count=3.
        clear_log();
        b0s = bd_cnt0;
        push_cmd(0, 32'd1, 3, 0, 1);
        wait_idle(300);
        chk("t1_count", 32'(log_k.size()), 32'd3);
        if (log_k.size() == 3) begin
            chk("t1_k0", log_k[0], 32'd1);
            chk("t1_k2", log_k[2], 32'd3);
            chk("t1_last", 32'({log_last[0], log_last[1], log_last[2]}), 32'b001);
        end
        chk("t1_bd", 32'(bd_cnt0 - b0s), 32'd1);

        // Backpressure: downstream stalled for 20 cycles with a result pending.
        clear_log();
        ord_mode = 2;
        push_cmd(1, 32'd100, 3, 1, 2);
        n = 0;
        while (!out_valid && n < 200) begin @(negedge clk); n++; end
        chk("t3_valid_seen", 32'(out_valid), 32'd1);
        s0 = start_cnt;
        repeat (20) @(negedge clk);
        chk("t3_no_start", 32'(start_cnt), 32'(s0));
        chk("t3_held_k", out_k, 32'd100);
        ord_mode = 0;
        wait_idle(300);
        chk("t3_count", 32'(log_k.size()), 32'd3);
        if (log_k.size() == 3) chk("t3_k_last", log_k[2], 32'd102);

        // Zero-count command.
        s0 = start_cnt;
        b0s = bd_cnt0;
        push_cmd(0, 32'd5, 0, 0, 0);
        repeat (6) @(negedge clk);
        chk("t4_no_start", 32'(start_cnt), 32'(s0));
        chk("t4_bd", 32'(bd_cnt0 - b0s), 32'd1);

        // Index wrap.
        clear_log();
        push_cmd(1, 32'hFFFF_FFFF, 2, 2, 2);
        wait_idle(300);
        chk("t5_count", 32'(log_k.size()), 32'd2);
        if (log_k.size() == 2) begin
            chk("t5_k0", log_k[0], 32'hFFFF_FFFF);
            chk("t5_k1", log_k[1], 32'h0000_0000);
        end

        // Watchdog: core never answers.
        hang = 1'b1;
        b1s = bd_cnt1;
        push_cmd(1, 32'd5, 2, 0, 0);
        n = 0;
        while (!err_timeout && n < 200) begin @(negedge clk); n++; end
        repeat (2) @(negedge clk);
        chk("t6_err", 32'(err_timeout), 32'd1);
        chk("t6_latency", 32'(err_rise_cyc - last_start_cyc), 32'd16);
        chk("t6_bd", 32'(bd_cnt1 - b1s), 32'd1);

        // Reset while waiting on the core.
        s0 = start_cnt;
        push_cmd(0, 32'd7, 3, 1, 1);
        n = 0;
        while (start_cnt == s0 && n < 100) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("t7_err", 32'(err_timeout), 32'd0);
        chk("t7_valid", 32'(out_valid), 32'd0);
        chk("t7_bd", 32'(batch_done), 32'd0);
        hang = 1'b0;
        repeat (4) @(negedge clk);

        // Random traffic with core and downstream stalls.
        stall_core = 1'b1;
        ord_mode = 1;
        for (int it = 0; it < 3000; it++) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0) begin
                int r;
                r = int'($urandom_range(0, 1));
                if ((r == 0 ? rq0.size() : rq1.size()) < 2)
                    push_cmd(r, ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFE : $urandom(),
                             int'($urandom_range(0, 4)), int'($urandom_range(0, 2)),
                             int'($urandom_range(0, 2)));
            end
            if (it == 1500) rst = 1'b1;
            else if (it == 1501) rst = 1'b0;
        end
        wait_idle(2000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

endmodule
